mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Sits directly downstream of the multi-cycle RISC-V core.
- Merges the core's instruction-fetch channel and data load/store channel onto one single-ported memory bus with valid/ready handshakes.
- Allows one outstanding transaction. Read data is buffered and returned to the channel that issued the read.

Parameters:
ADDR_WIDTH, 32, byte-address width on both sides
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_req_addr  in  ADDR_WIDTH  fetch address (core PC)
inst_req_valid  in  1  fetch request valid
inst_req_ready  out  1  fetch request accepted
inst_rdata  out  DATA_WIDTH  fetched instruction
inst_rvalid  out  1  instruction valid
inst_rready  in  1  core accepts instruction
data_addr  in  ADDR_WIDTH  load/store address
data_rd  in  1  load request valid
data_wr  in  1  store request valid
data_wdata  in  DATA_WIDTH  store data
data_wstrb  in  DATA_WIDTH/8  store byte strobes
data_req_ready  out  1  load/store request accepted
data_rdata  out  DATA_WIDTH  load data
data_rvalid  out  1  load data valid
data_rready  in  1  core accepts load data
mem_addr  out  ADDR_WIDTH  bus address, bits[1:0] forced 0
mem_wen  out  1  1 = write, 0 = read
mem_wdata  out  DATA_WIDTH  bus write data
mem_wstrb  out  DATA_WIDTH/8  bus write strobes
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_rdata  in  DATA_WIDTH  bus read data
mem_rvalid  in  1  bus read data valid
mem_rready  out  1  arbiter accepts read data

Behaviour:
- States: IDLE, ISSUE, WAIT, DELIVER. One-hot encoding. Reset goes to IDLE.
- Reset values:
  - All valid/ready outputs 0.
  - mem_addr, mem_wdata, mem_wstrb, mem_wen, inst_rdata, data_rdata all 0.
- IDLE: a request is present if data_rd, data_wr or inst_req_valid is high.
  - Data has fixed priority over inst.
  - The winner's ready (data_req_ready or inst_req_ready) is driven combinationally high in this state; the loser's ready stays 0.
  - Acceptance = valid & ready. On acceptance, latch into registers: address with [1:0] cleared; wen = data_wr; wdata; wstrb; and a source tag (inst or data).
  - Inst reads latch wstrb = 0. Data reads latch wstrb = 0.
  - If data_rd and data_wr are both high, the request is treated as a write.
  - Go to ISSUE.
- ISSUE: mem_req_valid = 1 with the latched fields held stable.
  - On mem_req_ready: a write goes to IDLE (write is complete); a read goes to WAIT.
  - Minimum request-accept to next IDLE for a write: 2 cycles.
- WAIT: mem_rready = 1. On mem_rvalid, capture mem_rdata into the tagged channel's rdata register and go to DELIVER.
- DELIVER: assert inst_rvalid or data_rvalid according to the tag; hold the data stable until the matching rready, then go to IDLE.
- A new request is never accepted outside IDLE. All ready outputs are 0 in ISSUE, WAIT and DELIVER.
- mem_rready is 0 outside WAIT. mem_rvalid outside WAIT is ignored and not consumed.
- Best-case read latency, core request acceptance to core rvalid: 3 cycles (ISSUE and WAIT each one cycle).
- rst mid-transaction:
  - Next cycle is IDLE with all outputs at reset values.
  - Captured data is discarded.
  - A bus response arriving after reset is not accepted.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: adds three 32-bit outputs, all cleared by rst and wrapping modulo 2^32.
  - perf_inst_cnt increments on each accepted fetch.
  - perf_data_cnt increments on each accepted load/store.
  - perf_wait_cnt increments on every cycle spent in ISSUE with mem_req_ready low, or in WAIT with mem_rvalid low.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Fetch: inst_req_addr=0x0000_1003, mem ready immediately, rdata=0x0000_0013 next cycle -> mem_addr=0x0000_1000, mem_wen=0; inst_rvalid=1 with inst_rdata=0x0000_0013 three cycles after acceptance; data_rvalid stays 0.
- Store: data_wr=1, addr=0x20, wdata=0xDEADBEEF, wstrb=4'b0011, mem_req_ready held low 3 cycles -> mem_req_valid held 4 cycles with fields stable; back to IDLE; no rvalid on either channel.
- Contention: data_rd and inst_req_valid both high in IDLE -> data_req_ready=1, inst_req_ready=0. After the load is delivered, the fetch is accepted in the next IDLE cycle.
- Backpressure: load returns 0x1234_5678, data_rready low 5 cycles -> data_rvalid and data_rdata held stable; no new request accepted until the handshake completes.
- Reset in WAIT: assert rst, then pulse mem_rvalid -> mem_rready=0, no rvalid on either channel, state IDLE.
- MEM_ARB_PERF_EN: 2 fetches + 1 store with 4 total bus stall cycles -> perf_inst_cnt=2, perf_data_cnt=1, perf_wait_cnt=4.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Fetch/load-store arbiter onto one single-ported memory bus, one outstanding txn.
// Optional MEM_ARB_PERF_EN adds accept and stall performance counters.
module mem_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   inst_req_addr,
  input  logic                    inst_req_valid,
  output logic                    inst_req_ready,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  output logic                    inst_rvalid,
  input  logic                    inst_rready,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic                    data_rd,
  input  logic                    data_wr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  output logic                    data_req_ready,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_rvalid,
  input  logic                    data_rready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_rvalid,
  output logic                    mem_rready
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]             perf_inst_cnt,
  output logic [31:0]             perf_data_cnt,
  output logic [31:0]             perf_wait_cnt
`endif
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(3);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    ISSUE   = 4'b0010,
    WAIT    = 4'b0100,
    DELIVER = 4'b1000
  } state_t;

  state_t state;
  logic   tag_data;
  logic   data_req;
  logic   data_acc;
  logic   inst_acc;
  logic   in_idle;
  logic   rsp_ack;

  assign in_idle  = (state == IDLE);
  assign data_req = data_rd | data_wr;

  // Data wins a tie; the fetch sees ready only when no data request exists.
  assign data_req_ready = in_idle & data_req;
  assign inst_req_ready = in_idle & ~data_req & inst_req_valid;

  assign data_acc = data_req_ready & data_req;
  assign inst_acc = inst_req_ready & inst_req_valid;

  assign rsp_ack = tag_data ? data_rready : inst_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tag_data      <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      mem_req_valid <= 1'b0;
      mem_rready    <= 1'b0;
      inst_rdata    <= '0;
      inst_rvalid   <= 1'b0;
      data_rdata    <= '0;
      data_rvalid   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_acc) begin
            mem_addr      <= data_addr & ~LOW_MASK;
            mem_wen       <= data_wr;
            mem_wdata     <= data_wdata;
            mem_wstrb     <= data_wr ? data_wstrb : SW'(0);
            tag_data      <= 1'b1;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end else if (inst_acc) begin
            mem_addr      <= inst_req_addr & ~LOW_MASK;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            tag_data      <= 1'b0;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (mem_wen) begin
              state <= IDLE;
            end else begin
              mem_rready <= 1'b1;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            mem_rready <= 1'b0;
            if (tag_data) begin
              data_rdata  <= mem_rdata;
              data_rvalid <= 1'b1;
            end else begin
              inst_rdata  <= mem_rdata;
              inst_rvalid <= 1'b1;
            end
            state <= DELIVER;
          end
        end
        DELIVER: begin
          if (rsp_ack) begin
            inst_rvalid <= 1'b0;
            data_rvalid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          mem_req_valid <= 1'b0;
          mem_rready    <= 1'b0;
          inst_rvalid   <= 1'b0;
          data_rvalid   <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic stall;

  assign stall = ((state == ISSUE) & ~mem_req_ready) |
                 ((state == WAIT) & ~mem_rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_inst_cnt <= '0;
      perf_data_cnt <= '0;
      perf_wait_cnt <= '0;
    end else begin
      if (inst_acc & ~data_acc) perf_inst_cnt <= perf_inst_cnt + 32'd1;
      if (data_acc)             perf_data_cnt <= perf_data_cnt + 32'd1;
      if (stall)                perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed + randomized bench for mem_req_arbiter with a word-memory reference model.
// Perf-counter checks compile in when MEM_ARB_PERF_EN is defined.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_req_addr;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic        inst_rready;
  logic [31:0] data_addr;
  logic        data_rd;
  logic        data_wr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_req_ready;
  logic [31:0] data_rdata;
  logic        data_rvalid;
  logic        data_rready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rready;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_inst_cnt;
  logic [31:0] perf_data_cnt;
  logic [31:0] perf_wait_cnt;
  int unsigned e_inst;
  int unsigned e_data;
  int unsigned e_wait;
`endif

  int errs   = 0;
  int checks = 0;

  logic [31:0] ref_mem[int];
  logic [31:0] bus_mem[int];

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req_addr(inst_req_addr), .inst_req_valid(inst_req_valid),
    .inst_req_ready(inst_req_ready), .inst_rdata(inst_rdata),
    .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
    .data_addr(data_addr), .data_rd(data_rd), .data_wr(data_wr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_req_ready(data_req_ready), .data_rdata(data_rdata),
    .data_rvalid(data_rvalid), .data_rready(data_rready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_inst_cnt(perf_inst_cnt), .perf_data_cnt(perf_data_cnt),
    .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a store replaces exactly the strobed bytes of the addressed word.
  task automatic ref_write(input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st);
    logic [31:0] mask;
    int key;
    key  = int'(addr >> 2);
    mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    if (!ref_mem.exists(key)) ref_mem[key] = 32'h0;
    ref_mem[key] = (ref_mem[key] & ~mask) | (wd & mask);
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 load+store (treated as store)
  task automatic do_txn(input int kind, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input int req_stall, input int resp_stall,
                        input int rr_stall, input bit contend);
    bit          wr;
    bit          is_data;
    int          key;
    int          bkey;
    logic [31:0] exp_rd;
    wr      = (kind >= 2);
    is_data = (kind != 0);
    key     = int'(addr >> 2);
    inst_req_addr = addr;
    data_addr     = addr;
    data_wdata    = wd;
    data_wstrb    = st;
    inst_req_valid = (kind == 0) || contend;
    data_rd        = (kind == 1) || (kind == 3);
    data_wr        = wr;
    #1;
    chk("accept_data_ready", data_req_ready, is_data);
    chk("accept_inst_ready", inst_req_ready, !is_data);
`ifdef MEM_ARB_PERF_EN
    if (is_data) e_data++; else e_inst++;
    e_wait += req_stall + (wr ? 0 : resp_stall);
`endif
    tick();
    inst_req_valid = 1'b0;
    data_rd        = 1'b0;
    data_wr        = 1'b0;
    for (int s = 0; s <= req_stall; s++) begin
      mem_req_ready = (s == req_stall);
      #1;
      chk("issue_valid", mem_req_valid, 1'b1);
      chk("issue_addr", mem_addr, addr & ~32'h3);
      chk("issue_wen", mem_wen, wr);
      chk("issue_wstrb", mem_wstrb, wr ? st : 4'h0);
      if (wr) chk("issue_wdata", mem_wdata, wd);
      chk("issue_rvalids", {inst_rvalid, data_rvalid}, 2'b00);
      if (s == req_stall && mem_wen) begin
        bkey = int'(mem_addr >> 2);
        if (!bus_mem.exists(bkey)) bus_mem[bkey] = 32'h0;
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) bus_mem[bkey][8*b +: 8] = mem_wdata[8*b +: 8];
      end
      tick();
    end
    mem_req_ready = 1'b0;
    if (wr) begin
      ref_write(addr, wd, st);
      #1;
      chk("wr_done_valid", mem_req_valid, 1'b0);
      chk("wr_done_rvalids", {inst_rvalid, data_rvalid}, 2'b00);
      return;
    end
    exp_rd = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    for (int s = 0; s <= resp_stall; s++) begin
      mem_rvalid = (s == resp_stall);
      bkey = int'(mem_addr >> 2);
      if (s == resp_stall)
        mem_rdata = bus_mem.exists(bkey) ? bus_mem[bkey] : 32'h0;
      else
        mem_rdata = $urandom;
      #1;
      chk("wait_rready", mem_rready, 1'b1);
      chk("wait_rvalids", {inst_rvalid, data_rvalid}, 2'b00);
      tick();
    end
    for (int s = 0; s <= rr_stall; s++) begin
      if (is_data) data_rready = (s == rr_stall);
      else         inst_rready = (s == rr_stall);
      inst_req_valid = 1'b1;
      data_rd        = 1'b1;
      mem_rvalid     = 1'b1;
      mem_rdata      = $urandom;
      #1;
      chk("dlv_inst_rvalid", inst_rvalid, !is_data);
      chk("dlv_data_rvalid", data_rvalid, is_data);
      chk("dlv_rdata", is_data ? data_rdata : inst_rdata, exp_rd);
      chk("dlv_readies", {inst_req_ready, data_req_ready}, 2'b00);
      chk("dlv_mem_rready", mem_rready, 1'b0);
      tick();
    end
    inst_req_valid = 1'b0;
    data_rd        = 1'b0;
    inst_rready    = 1'b0;
    data_rready    = 1'b0;
    mem_rvalid     = 1'b0;
    #1;
    chk("post_rvalids", {inst_rvalid, data_rvalid}, 2'b00);
  endtask

  initial begin
    int k;
    int lo;
    rst = 1'b1;
    inst_req_addr = '0; inst_req_valid = 1'b0; inst_rready = 1'b0;
    data_addr = '0; data_rd = 1'b0; data_wr = 1'b0;
    data_wdata = '0; data_wstrb = '0; data_rready = 1'b0;
    mem_req_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
`ifdef MEM_ARB_PERF_EN
    e_inst = 0; e_data = 0; e_wait = 0;
`endif
    for (int i = 8; i < 16; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    ref_mem[9] = 32'h1234_5678;  bus_mem[9] = 32'h1234_5678;
    ref_mem[32'h400] = 32'h13;   bus_mem[32'h400] = 32'h13;

    tick(); tick();
    chk("rst_valids", {mem_req_valid, mem_rready, inst_rvalid, data_rvalid}, 4'h0);
    chk("rst_fields", {mem_addr, mem_wdata}, 64'h0);
    chk("rst_wen_strb", {mem_wen, mem_wstrb}, 5'h0);
    chk("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
    chk("rst_readies", {inst_req_ready, data_req_ready}, 2'b00);
    rst = 1'b0;
    #1;

    do_txn(0, 32'h0000_1003, 32'h0, 4'h0, 0, 0, 0, 1'b0);
    do_txn(2, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0011, 3, 0, 0, 1'b0);
    do_txn(1, 32'h0000_0020, 32'h0, 4'h0, 0, 0, 0, 1'b1);
    do_txn(0, 32'h0000_1003, 32'h0, 4'h0, 0, 0, 0, 1'b0);
    do_txn(1, 32'h0000_0026, 32'h0, 4'h0, 0, 0, 5, 1'b0);
    chk("bp_rdata_value", data_rdata, 32'h1234_5678);

    inst_req_addr  = 32'h0000_1003;
    inst_req_valid = 1'b1;
    tick();
    inst_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rw_in_wait", mem_rready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef MEM_ARB_PERF_EN
    e_inst = 0; e_data = 0; e_wait = 0;
`endif
    chk("rw_rready", mem_rready, 1'b0);
    chk("rw_valids", {mem_req_valid, inst_rvalid, data_rvalid}, 3'b000);
    chk("rw_addr", mem_addr, 32'h0);
    chk("rw_rdata_clear", {inst_rdata, data_rdata}, 64'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAAAA_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_late_rsp_rvalid", {inst_rvalid, data_rvalid}, 2'b00);
    chk("rw_late_rsp_rready", mem_rready, 1'b0);
    chk("rw_late_rsp_rdata", inst_rdata, 32'h0);
    inst_req_valid = 1'b1;
    #1;
    chk("rw_idle_ready", inst_req_ready, 1'b1);
    inst_req_valid = 1'b0;
    #1;

`ifdef MEM_ARB_PERF_EN
    do_txn(0, 32'h0000_1003, 32'h0, 4'h0, 1, 1, 0, 1'b0);
    do_txn(0, 32'h0000_1003, 32'h0, 4'h0, 0, 1, 0, 1'b0);
    do_txn(2, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 1, 0, 0, 1'b0);
    chk("perf_inst", perf_inst_cnt, 32'd2);
    chk("perf_data", perf_data_cnt, 32'd1);
    chk("perf_wait", perf_wait_cnt, 32'd4);
`endif

    for (int t = 0; t < 80; t++) begin
      k  = $urandom_range(0, 3);
      lo = $urandom_range(0, 3);
      do_txn(k, 32'h20 + 32'($urandom_range(0, 7) << 2) + 32'(lo),
             $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 2), (k != 0) && ($urandom_range(0, 1) == 1));
    end

`ifdef MEM_ARB_PERF_EN
    chk("perf_inst_total", perf_inst_cnt, 32'(e_inst));
    chk("perf_data_total", perf_data_cnt, 32'(e_data));
    chk("perf_wait_total", perf_wait_cnt, 32'(e_wait));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
